// File: rtl/clk_monitor_pkg.sv
// Shared types and helpers for the clock-health monitor.
package clk_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      RUN   = 2'd2,
      STUCK = 2'd3
   } state_t;

   function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/clk_monitor_edge_detect.sv
// Synchronizes the monitored clock into clk and emits a registered one-cycle rise pulse.
module clk_monitor_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic meas_in,
   output logic level,
   output logic rise_ev
);

   logic [SYNC_STAGES-1:0] sync_q;

   // level is the synchronized input delayed once so it lines up with rise_ev
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         level   <= 1'b0;
         rise_ev <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], meas_in};
         level   <= sync_q[SYNC_STAGES-1];
         rise_ev <= sync_q[SYNC_STAGES-1] & ~level;
      end
   end

endmodule

// File: rtl/clk_monitor.sv
// Measures period and high time of meas_in in clk cycles; reports range, lock and stuck status.
module clk_monitor
   import clk_monitor_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EXP_PERIOD  = 10,
   parameter int unsigned TOL         = 1,
   parameter int unsigned LOCK_CNT    = 4,
   parameter int unsigned TIMEOUT     = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             meas_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             in_range,
   output logic             locked,
   output logic             stuck
);

   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
   localparam int unsigned LOCK_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state_q, state_d;

   logic [CNT_W-1:0]  per_q, per_d;
   logic [CNT_W-1:0]  high_q, high_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [LOCK_W-1:0] lock_q, lock_d;
   logic [CNT_W-1:0]  period_d, high_time_d;
   logic              meas_valid_d, in_range_d, locked_d, stuck_d;

   logic              level, rise_ev;
   logic              timeout_c, meas_ok_c;
   logic [CNT_W-1:0]  per_inc_c, high_inc_c;
   logic [LOCK_W-1:0] lock_inc_c;

   clk_monitor_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge (
      .clk     (clk),
      .rst     (rst),
      .meas_in (meas_in),
      .level   (level),
      .rise_ev (rise_ev)
   );

   // A coincident rise always beats timeout expiry
   assign timeout_c  = !rise_ev && (idle_q >= IDLE_W'(TIMEOUT - 1));
   assign meas_ok_c  = (per_q != CNT_MAX) &&
                       (abs_diff(32'(per_q), 32'(EXP_PERIOD)) <= 32'(TOL));
   assign per_inc_c  = (per_q == CNT_MAX) ? per_q : per_q + CNT_W'(1);
   assign high_inc_c = (high_q == CNT_MAX) ? high_q : high_q + CNT_W'(1);
   assign lock_inc_c = (lock_q >= LOCK_W'(LOCK_CNT)) ? lock_q : lock_q + LOCK_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         per_q      <= '0;
         high_q     <= '0;
         idle_q     <= '0;
         lock_q     <= '0;
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         in_range   <= 1'b0;
         locked     <= 1'b0;
         stuck      <= 1'b0;
      end else begin
         state_q    <= state_d;
         per_q      <= per_d;
         high_q     <= high_d;
         idle_q     <= idle_d;
         lock_q     <= lock_d;
         period     <= period_d;
         high_time  <= high_time_d;
         meas_valid <= meas_valid_d;
         in_range   <= in_range_d;
         locked     <= locked_d;
         stuck      <= stuck_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = ARM;
         ARM:     if (rise_ev) state_d = RUN; else if (timeout_c) state_d = STUCK;
         RUN:     if (timeout_c) state_d = STUCK;
         STUCK:   if (rise_ev) state_d = RUN;
         default: state_d = IDLE;
      endcase
      if (!ena) state_d = IDLE;
   end

   always_comb begin
      per_d        = per_q;
      high_d       = high_q;
      idle_d       = idle_q;
      lock_d       = lock_q;
      period_d     = period;
      high_time_d  = high_time;
      meas_valid_d = 1'b0;
      in_range_d   = in_range;
      locked_d     = locked;
      stuck_d      = stuck;

      case (state_q)
         IDLE: begin
            per_d  = '0;
            high_d = '0;
            idle_d = '0;
            lock_d = '0;
         end
         // First edge after arming or a stall only restarts the counters
         ARM, STUCK: begin
            if (rise_ev) begin
               per_d   = CNT_W'(1);
               high_d  = CNT_W'(1);
               idle_d  = '0;
               stuck_d = 1'b0;
            end else if (state_q == ARM) begin
               idle_d = idle_q + IDLE_W'(1);
            end
         end
         RUN: begin
            if (rise_ev) begin
               period_d     = per_q;
               high_time_d  = high_q;
               in_range_d   = meas_ok_c;
               meas_valid_d = 1'b1;
               per_d        = CNT_W'(1);
               high_d       = CNT_W'(1);
               idle_d       = '0;
               if (meas_ok_c) begin
                  lock_d   = lock_inc_c;
                  locked_d = (lock_inc_c == LOCK_W'(LOCK_CNT));
               end else begin
                  lock_d   = '0;
                  locked_d = 1'b0;
               end
            end else begin
               per_d  = per_inc_c;
               idle_d = idle_q + IDLE_W'(1);
               if (level) high_d = high_inc_c;
            end
         end
         default: ;
      endcase

      if (timeout_c && ((state_q == ARM) || (state_q == RUN))) begin
         stuck_d    = 1'b1;
         locked_d   = 1'b0;
         lock_d     = '0;
         in_range_d = 1'b0;
         idle_d     = '0;
      end

      if (!ena) begin
         per_d        = '0;
         high_d       = '0;
         idle_d       = '0;
         lock_d       = '0;
         meas_valid_d = 1'b0;
         in_range_d   = 1'b0;
         locked_d     = 1'b0;
         stuck_d      = 1'b0;
      end
   end

endmodule
